// File: rtl/logic_probe_channels.sv
// logic_probe_channels: multi-channel logic probe.
// Each channel's high/low comparator outputs are synchronized, encoded into a
// 2-bit level code, and edge-counted over a fixed measurement window. At the
// end of each window the live counts move into snapshot registers that can be
// read over a simple pipelined read port. Sticky per-channel error flags catch
// the impossible "above high but below low" comparator state.
//
// Optional feature: define LOGIC_PROBE_PULSE_STRETCH_EN to build per-channel
// pulse-stretch timers that drive pulse_led. Without the macro, pulse_led and
// status bit 3 are tied to 0 and no timers are built.
//
// Read port handshake: rd_req is a one-cycle strobe and may be asserted every
// cycle. Each accepted strobe produces rd_ack exactly one cycle later, with
// rd_data registered to match. rd_data is 0 whenever rd_ack is 0. A strobe
// sampled together with reset is dropped.

module logic_probe_channels #(
  parameter int CHANNELS       = 4,
  parameter int COUNTER_BITS   = 24,
  parameter int WINDOW_CYCLES  = 32400000,
  parameter int STRETCH_CYCLES = 3240000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     comp_hi,
  input  logic [CHANNELS-1:0]     comp_lo,
  input  logic                    rd_req,
  input  logic [7:0]              rd_addr,
  output logic [31:0]             rd_data,
  output logic                    rd_ack,
  output logic [2*CHANNELS-1:0]   level,
  output logic                    window_done,
  output logic [CHANNELS-1:0]     pulse_led
);

  // Level codes
  localparam logic [1:0] LVL_LOW  = 2'b00;
  localparam logic [1:0] LVL_MID  = 2'b01;
  localparam logic [1:0] LVL_HIGH = 2'b10;
  localparam logic [1:0] LVL_ERR  = 2'b11;

  localparam int                     WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);
  localparam logic [7:0]             SEQ_ADDR = 8'(4 * CHANNELS);

  // ---------------------------------------------------------------------------
  // Synchronizers and level encoding
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0]   hi_s1_q, hi_s2_q;
  logic [CHANNELS-1:0]   lo_s1_q, lo_s2_q;
  logic [2*CHANNELS-1:0] level_q, level_d;

  // Two-flop synchronizers for the asynchronous comparator outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_s1_q <= '0;
      hi_s2_q <= '0;
      lo_s1_q <= '0;
      lo_s2_q <= '0;
    end else begin
      hi_s1_q <= comp_hi;
      hi_s2_q <= hi_s1_q;
      lo_s1_q <= comp_lo;
      lo_s2_q <= lo_s1_q;
    end
  end

  // Encode the synchronized comparator pair into a level code
  always_comb begin
    level_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      case ({hi_s2_q[n], lo_s2_q[n]})
        2'b00:   level_d[2*n +: 2] = LVL_LOW;
        2'b01:   level_d[2*n +: 2] = LVL_MID;
        2'b11:   level_d[2*n +: 2] = LVL_HIGH;
        default: level_d[2*n +: 2] = LVL_ERR;
      endcase
    end
  end

  // Registered level code; reset value LOW doubles as the "previous level"
  always_ff @(posedge clk) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end

  assign level = level_q;

  // ---------------------------------------------------------------------------
  // Edge events: compare the level about to be registered with the current one
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] rise_ev, fall_ev;

  // Detect transitions into HIGH and into LOW from any other code
  always_comb begin
    rise_ev = '0;
    fall_ev = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      rise_ev[n] = (level_d[2*n +: 2] == LVL_HIGH) && (level_q[2*n +: 2] != LVL_HIGH);
      fall_ev[n] = (level_d[2*n +: 2] == LVL_LOW)  && (level_q[2*n +: 2] != LVL_LOW);
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement window
  // ---------------------------------------------------------------------------
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_term;
  logic [31:0]      seq_q, seq_d;
  logic             window_done_q, window_done_d;

  // Window counter runs 0..WINDOW_CYCLES-1; terminal cycle closes the window
  always_comb begin
    win_term      = (win_cnt_q == WIN_LAST);
    win_cnt_d     = win_term ? '0 : win_cnt_q + WIN_W'(1);
    seq_d         = win_term ? seq_q + 32'd1 : seq_q;
    window_done_d = win_term;
  end

  // Window counter, sequence number and window_done pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q     <= '0;
      seq_q         <= '0;
      window_done_q <= 1'b0;
    end else begin
      win_cnt_q     <= win_cnt_d;
      seq_q         <= seq_d;
      window_done_q <= window_done_d;
    end
  end

  assign window_done = window_done_q;

  // ---------------------------------------------------------------------------
  // Live and snapshot edge counters
  // ---------------------------------------------------------------------------
  logic [COUNTER_BITS-1:0] rise_live_q [CHANNELS];
  logic [COUNTER_BITS-1:0] rise_live_d [CHANNELS];
  logic [COUNTER_BITS-1:0] fall_live_q [CHANNELS];
  logic [COUNTER_BITS-1:0] fall_live_d [CHANNELS];
  logic [COUNTER_BITS-1:0] rise_snap_q [CHANNELS];
  logic [COUNTER_BITS-1:0] rise_snap_d [CHANNELS];
  logic [COUNTER_BITS-1:0] fall_snap_q [CHANNELS];
  logic [COUNTER_BITS-1:0] fall_snap_d [CHANNELS];

  // Saturating counters; at terminal count the live value moves to the
  // snapshot and an edge in that same cycle seeds the next window with 1
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      rise_snap_d[n] = rise_snap_q[n];
      fall_snap_d[n] = fall_snap_q[n];
      rise_live_d[n] = rise_live_q[n];
      fall_live_d[n] = fall_live_q[n];
      if (win_term) begin
        rise_snap_d[n] = rise_live_q[n];
        fall_snap_d[n] = fall_live_q[n];
        rise_live_d[n] = rise_ev[n] ? CNT_ONE : '0;
        fall_live_d[n] = fall_ev[n] ? CNT_ONE : '0;
      end else begin
        if (rise_ev[n] && (rise_live_q[n] != CNT_MAX)) rise_live_d[n] = rise_live_q[n] + CNT_ONE;
        if (fall_ev[n] && (fall_live_q[n] != CNT_MAX)) fall_live_d[n] = fall_live_q[n] + CNT_ONE;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < CHANNELS; n++) begin
        rise_live_q[n] <= '0;
        fall_live_q[n] <= '0;
        rise_snap_q[n] <= '0;
        fall_snap_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        rise_live_q[n] <= rise_live_d[n];
        fall_live_q[n] <= fall_live_d[n];
        rise_snap_q[n] <= rise_snap_d[n];
        fall_snap_q[n] <= fall_snap_d[n];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] err_q, err_d;

  // Set while level is ERROR, clear on a status read; set wins over clear
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      err_d[n] = err_q[n];
      if (rd_req && (rd_addr == 8'(4 * n + 2))) err_d[n] = 1'b0;
      if (level_q[2*n +: 2] == LVL_ERR)         err_d[n] = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  // ---------------------------------------------------------------------------
  // Pulse stretch indicators
  // ---------------------------------------------------------------------------
`ifdef LOGIC_PROBE_PULSE_STRETCH_EN
  localparam int              ST_W    = $clog2(STRETCH_CYCLES + 2);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);

  logic [ST_W-1:0] st_q [CHANNELS];
  logic [ST_W-1:0] st_d [CHANNELS];

  // Any level change reloads the timer; otherwise it counts down to zero
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      st_d[n] = st_q[n];
      if (level_d[2*n +: 2] != level_q[2*n +: 2]) st_d[n] = ST_LOAD;
      else if (st_q[n] != '0)                     st_d[n] = st_q[n] - ST_W'(1);
    end
  end

  // Stretch timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < CHANNELS; n++) st_q[n] <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) st_q[n] <= st_d[n];
    end
  end

  // Indicator is lit while the timer is running
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) pulse_led[n] = (st_q[n] != '0);
  end
`else
  assign pulse_led = '0;
`endif

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_ack_q;

  // Word decode: a = 4*ch + k, sequence number just past the last channel
  always_comb begin
    rd_data_d = '0;
    if (rd_req) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (rd_addr[7:2] == 6'(n)) begin
          case (rd_addr[1:0])
            2'd0:    rd_data_d = 32'(rise_snap_q[n]);
            2'd1:    rd_data_d = 32'(fall_snap_q[n]);
            2'd2:    rd_data_d = {28'd0, pulse_led[n], err_q[n], level_q[2*n +: 2]};
            default: rd_data_d = '0;
          endcase
        end
      end
      if (rd_addr == SEQ_ADDR) rd_data_d = seq_q;
    end
  end

  // Read response registers; a strobe in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_req;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_ack  = rd_ack_q;

endmodule

// File: tb/tb_logic_probe_channels.sv
// Testbench for logic_probe_channels: directed scenarios against two
// instances sharing stimulus, one with 24-bit counters and one with 3-bit
// counters, both with a 100-cycle window.
module tb_logic_probe_channels;

  localparam int CH  = 4;
  localparam int WIN = 100;
  localparam int STR = 10;
`ifdef LOGIC_PROBE_PULSE_STRETCH_EN
  localparam int EXP_STRETCH = STR;
`else
  localparam int EXP_STRETCH = 0;
`endif

  logic          clk;
  logic          reset;
  logic [CH-1:0] comp_hi, comp_lo;
  logic          rd_req;
  logic [7:0]    rd_addr;
  logic [31:0]   rd_data, rd_data_sat;
  logic          rd_ack, rd_ack_sat;
  logic [2*CH-1:0] level, level_sat;
  logic          window_done, window_done_sat;
  logic [CH-1:0] pulse_led, pulse_led_sat;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] d, ds;
  logic        ack;
  int          cyc;
  bit          ok;

  logic_probe_channels #(
    .CHANNELS(CH), .COUNTER_BITS(24), .WINDOW_CYCLES(WIN), .STRETCH_CYCLES(STR)
  ) dut (
    .clk(clk), .reset(reset), .comp_hi(comp_hi), .comp_lo(comp_lo),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .level(level), .window_done(window_done), .pulse_led(pulse_led)
  );

  logic_probe_channels #(
    .CHANNELS(CH), .COUNTER_BITS(3), .WINDOW_CYCLES(WIN), .STRETCH_CYCLES(STR)
  ) dut_sat (
    .clk(clk), .reset(reset), .comp_hi(comp_hi), .comp_lo(comp_lo),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_sat), .rd_ack(rd_ack_sat),
    .level(level_sat), .window_done(window_done_sat), .pulse_led(pulse_led_sat)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 ns after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] dd,
                         output logic [31:0] dds, output logic aa);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    aa  = rd_ack;
    dd  = rd_data;
    dds = rd_data_sat;
    rd_req  = 1'b0;
    rd_addr = 8'd0;
  endtask

  task automatic wait_window_done(output int cycles, output bit found);
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      cycles++;
      if (window_done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Reset state and rd_req dropped during reset
  task automatic test_reset();
    reset = 1'b1; comp_hi = '0; comp_lo = '0; rd_req = 1'b1; rd_addr = 8'd0;
    tick(2);
    n_checks++; if (rd_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack got=%b want=0", rd_ack); end
    n_checks++; if (rd_data !== 32'd0) begin n_errors++; $display("FAIL reset_data got=%0h want=0", rd_data); end
    n_checks++; if (level !== '0) begin n_errors++; $display("FAIL reset_level got=%0h want=0", level); end
    n_checks++; if (window_done !== 1'b0) begin n_errors++; $display("FAIL reset_wdone got=%b want=0", window_done); end
    n_checks++; if (pulse_led !== '0) begin n_errors++; $display("FAIL reset_led got=%0h want=0", pulse_led); end
    reset = 1'b0; rd_req = 1'b0;
    do_read(8'd16, d, ds, ack);
    n_checks++; if (ack !== 1'b1 || d !== 32'd0) begin n_errors++; $display("FAIL reset_seq ack=%b got=%0d want=0", ack, d); end
    do_read(8'd0, d, ds, ack);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL reset_snap got=%0d want=0", d); end
  endtask

  // Seven full pulses on ch0 in the first window
  task automatic test_edge_count();
    for (int i = 0; i < 7; i++) begin
      comp_hi[0] = 1'b1; comp_lo[0] = 1'b1;
      if (i == 0) begin
        tick(2);
        n_checks++; if (level[1:0] !== 2'b00) begin n_errors++; $display("FAIL latency_early got=%b want=00", level[1:0]); end
        tick();
        n_checks++; if (level[1:0] !== 2'b10) begin n_errors++; $display("FAIL latency_high got=%b want=10", level[1:0]); end
        tick();
      end else begin
        tick(4);
      end
      comp_hi[0] = 1'b0; comp_lo[0] = 1'b0;
      tick(4);
    end
    wait_window_done(cyc, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL window1_timeout got=none want=window_done"); end
    tick();
    n_checks++; if (window_done !== 1'b0) begin n_errors++; $display("FAIL wdone_width got=%b want=0", window_done); end
    do_read(8'd0, d, ds, ack);
    n_checks++; if (ack !== 1'b1 || d !== 32'd7) begin n_errors++; $display("FAIL rise_ch0 ack=%b got=%0d want=7", ack, d); end
    n_checks++; if (ds !== 32'd7) begin n_errors++; $display("FAIL rise_ch0_sat got=%0d want=7", ds); end
    do_read(8'd1, d, ds, ack);
    n_checks++; if (d !== 32'd7) begin n_errors++; $display("FAIL fall_ch0 got=%0d want=7", d); end
    do_read(8'd16, d, ds, ack);
    n_checks++; if (d !== 32'd1) begin n_errors++; $display("FAIL seq_first got=%0d want=1", d); end
    do_read(8'd2, d, ds, ack);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL status_ch0 got=%0h want=0", d); end
  endtask

  // Sticky error flag: one-cycle ERROR on ch1, held ERROR on ch3
  task automatic test_error();
    comp_hi[1] = 1'b1; comp_lo[1] = 1'b0;
    tick();
    comp_hi[1] = 1'b0; comp_lo[1] = 1'b1;
    tick(2);
    n_checks++; if (level[3:2] !== 2'b11) begin n_errors++; $display("FAIL level_err got=%b want=11", level[3:2]); end
    tick();
    n_checks++; if (level[3:2] !== 2'b01) begin n_errors++; $display("FAIL level_mid got=%b want=01", level[3:2]); end
    tick(15);
    do_read(8'd6, d, ds, ack);
    n_checks++; if (d !== 32'h5) begin n_errors++; $display("FAIL err_set got=%0h want=5", d); end
    do_read(8'd6, d, ds, ack);
    n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL err_clear got=%0h want=1", d); end
    comp_hi[3] = 1'b1; comp_lo[3] = 1'b0;
    tick(15);
    do_read(8'd14, d, ds, ack);
    n_checks++; if (d !== 32'h7) begin n_errors++; $display("FAIL err_held1 got=%0h want=7", d); end
    do_read(8'd14, d, ds, ack);
    n_checks++; if (d !== 32'h7) begin n_errors++; $display("FAIL err_held2 got=%0h want=7", d); end
    comp_hi[3] = 1'b0; comp_lo[3] = 1'b0;
    tick(5);
  endtask

  // Twenty rising edges on ch2 in one window; 3-bit counters saturate at 7
  task automatic test_saturate();
    wait_window_done(cyc, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL sat_align_timeout got=none want=window_done"); end
    for (int i = 0; i < 20; i++) begin
      comp_hi[2] = 1'b1; comp_lo[2] = 1'b1;
      tick(2);
      comp_hi[2] = 1'b0; comp_lo[2] = 1'b0;
      tick(2);
    end
    wait_window_done(cyc, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL sat_timeout got=none want=window_done"); end
    do_read(8'd8, d, ds, ack);
    n_checks++; if (d !== 32'd20) begin n_errors++; $display("FAIL rise_ch2 got=%0d want=20", d); end
    n_checks++; if (ds !== 32'd7) begin n_errors++; $display("FAIL rise_ch2_sat got=%0d want=7", ds); end
    do_read(8'd9, d, ds, ack);
    n_checks++; if (d !== 32'd20) begin n_errors++; $display("FAIL fall_ch2 got=%0d want=20", d); end
    n_checks++; if (ds !== 32'd7) begin n_errors++; $display("FAIL fall_ch2_sat got=%0d want=7", ds); end
  endtask

  // Rising edge registered on the terminal cycle belongs to the next window
  task automatic test_terminal_edge();
    wait_window_done(cyc, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL term_align_timeout got=none want=window_done"); end
    tick(WIN - 3);
    comp_hi[0] = 1'b1; comp_lo[0] = 1'b1;
    wait_window_done(cyc, ok);
    n_checks++; if (!ok || cyc != 3) begin n_errors++; $display("FAIL term_timing got=%0d want=3", cyc); end
    n_checks++; if (level[1:0] !== 2'b10) begin n_errors++; $display("FAIL term_level got=%b want=10", level[1:0]); end
    do_read(8'd0, d, ds, ack);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL term_excluded got=%0d want=0", d); end
    wait_window_done(cyc, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL term_next_timeout got=none want=window_done"); end
    do_read(8'd0, d, ds, ack);
    n_checks++; if (d !== 32'd1) begin n_errors++; $display("FAIL term_next got=%0d want=1", d); end
  endtask

  // Consecutive read strobes: snapshot, status, out of range, reserved, past seq
  task automatic test_back_to_back();
    logic [7:0]  addrs [5];
    logic [31:0] exp_d [5];
    addrs[0] = 8'd0;   exp_d[0] = 32'd1;
    addrs[1] = 8'd2;   exp_d[1] = 32'h2;
    addrs[2] = 8'd200; exp_d[2] = 32'd0;
    addrs[3] = 8'd3;   exp_d[3] = 32'd0;
    addrs[4] = 8'd17;  exp_d[4] = 32'd0;
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_addr = addrs[i];
      tick();
      n_checks++;
      if (rd_ack !== 1'b1 || rd_data !== exp_d[i]) begin
        n_errors++; $display("FAIL b2b_%0d ack=%b got=%0h want=%0h", i, rd_ack, rd_data, exp_d[i]);
      end
    end
    rd_req = 1'b0; rd_addr = 8'd0;
    tick();
    n_checks++; if (rd_ack !== 1'b0 || rd_data !== 32'd0) begin n_errors++; $display("FAIL b2b_idle ack=%b got=%0h want=0", rd_ack, rd_data); end
  endtask

  // Stretch duration, then reset mid-stretch with a read strobe in the reset cycle
  task automatic test_stretch_and_reset();
    int high_cnt;
    high_cnt = 0;
    comp_lo[2] = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 2) begin
        n_checks++; if (pulse_led[2] !== 1'b0) begin n_errors++; $display("FAIL led_early got=%b want=0", pulse_led[2]); end
      end
      if (i == 3) begin
        n_checks++; if (pulse_led[2] !== (EXP_STRETCH > 0)) begin n_errors++; $display("FAIL led_start got=%b want=%b", pulse_led[2], EXP_STRETCH > 0); end
      end
      if (pulse_led[2]) high_cnt++;
    end
    n_checks++; if (high_cnt != EXP_STRETCH) begin n_errors++; $display("FAIL led_len got=%0d want=%0d", high_cnt, EXP_STRETCH); end
    comp_lo[2] = 1'b0;
    tick(5);
    n_checks++; if (pulse_led[2] !== (EXP_STRETCH > 0)) begin n_errors++; $display("FAIL led_mid got=%b want=%b", pulse_led[2], EXP_STRETCH > 0); end
    reset = 1'b1; rd_req = 1'b1; rd_addr = 8'd0;
    tick();
    n_checks++; if (pulse_led !== '0) begin n_errors++; $display("FAIL led_reset got=%0h want=0", pulse_led); end
    n_checks++; if (rd_ack !== 1'b0 || rd_data !== 32'd0) begin n_errors++; $display("FAIL reset_rd ack=%b got=%0h want=0", rd_ack, rd_data); end
    n_checks++; if (level !== '0) begin n_errors++; $display("FAIL reset_mid_level got=%0h want=0", level); end
    reset = 1'b0; rd_req = 1'b0;
    // ch0 is still driven HIGH, so the fresh window sees one rising edge
    wait_window_done(cyc, ok);
    n_checks++; if (!ok || cyc != WIN) begin n_errors++; $display("FAIL post_reset_window got=%0d want=%0d", cyc, WIN); end
    do_read(8'd0, d, ds, ack);
    n_checks++; if (d !== 32'd1) begin n_errors++; $display("FAIL post_reset_rise got=%0d want=1", d); end
    do_read(8'd1, d, ds, ack);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL post_reset_fall got=%0d want=0", d); end
    do_read(8'd16, d, ds, ack);
    n_checks++; if (d !== 32'd1) begin n_errors++; $display("FAIL post_reset_seq got=%0d want=1", d); end
    do_read(8'd8, d, ds, ack);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL post_reset_ch2 got=%0d want=0", d); end
  endtask

  // Scenario sequence and final report
  initial begin
    reset = 1'b1; comp_hi = '0; comp_lo = '0; rd_req = 1'b0; rd_addr = 8'd0;
    test_reset();
    test_edge_count();
    test_error();
    test_saturate();
    test_terminal_edge();
    test_back_to_back();
    test_stretch_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/logic_probe_channels.md
LOGIC_PROBE_CHANNELS -- requirements
Module: logic_probe_channels

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of probe channels, 1..16.
REQ-002 SHALL have parameter COUNTER_BITS, default 24: edge counter width, 1..32.
REQ-003 SHALL have parameter WINDOW_CYCLES, default 32400000: measurement window length in clk cycles (1 s at 32.4 MHz), >= 2.
REQ-004 SHALL have parameter STRETCH_CYCLES, default 3240000: pulse indicator hold time in cycles.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port comp_hi, input, CHANNELS: asynchronous, 1 = input above the high threshold.
REQ-008 SHALL have port comp_lo, input, CHANNELS: asynchronous, 1 = input above the low threshold.
REQ-009 SHALL have port rd_req, input, 1: one-cycle read strobe.
REQ-010 SHALL have port rd_addr, input, 8: read word address.
REQ-011 SHALL have port rd_data, output, 32: read data.
REQ-012 SHALL have port rd_ack, output, 1: read data valid.
REQ-013 SHALL have port level, output, 2*CHANNELS: current level code per channel, channel n at bits [2n+1:2n].
REQ-014 SHALL have port window_done, output, 1: one-cycle pulse when a window closes.
REQ-015 SHALL have port pulse_led, output, CHANNELS: stretched activity indicator per channel.

Function
REQ-016 SHALL pass each comp_hi and comp_lo bit through a 2-flop synchronizer, then register the level code, giving 3 cycles from input change to level.
REQ-017 SHALL encode level as follows: hi=0/lo=0 gives LOW 2'b00; hi=0/lo=1 gives MID/float 2'b01; hi=1/lo=1 gives HIGH 2'b10; hi=1/lo=0 gives ERROR 2'b11.
REQ-018 SHALL increment a live rising counter on every transition into HIGH from any other code.
REQ-019 SHALL increment a live falling counter on every transition into LOW from any other code.
REQ-020 SHALL saturate edge counters at 2^COUNTER_BITS-1 and never wrap.
REQ-021 SHALL run the window counter 0..WINDOW_CYCLES-1 and wrap it to 0.
REQ-022 SHALL, at terminal count, copy all live counters into snapshot registers, clear the live counters, pulse window_done for one cycle, and increment a 32-bit wrapping window sequence number.
REQ-023 SHALL, on an edge in the terminal cycle, exclude it from the snapshot and load the live counter with 1.
REQ-024 SHALL set a per-channel sticky error flag whenever level is ERROR.
REQ-025 SHALL clear the error flag when that channel's status word is read; a set condition in the same cycle as the read leaves the flag set.
REQ-026 SHALL accept rd_req every cycle, pipelined: rd_ack pulses exactly 1 cycle after each rd_req, with rd_data registered to match; rd_data is 0 when rd_ack is 0.
REQ-027 SHALL decode word address a = 4*ch+k for ch < CHANNELS:
- k=0: rising snapshot, zero-extended.
- k=1: falling snapshot, zero-extended.
- k=2: status, bits[1:0] = level, bit2 = error flag, bit3 = pulse_led.
- k=3: 0.
REQ-028 SHALL return the window sequence number at address 4*CHANNELS and 0 at all higher addresses.

Reset
REQ-029 SHALL, with reset high at a clk edge, clear synchronizers, level (LOW), live and snapshot counters, window counter, sequence number, error flags, stretch timers, rd_data, rd_ack, window_done and pulse_led to 0.
REQ-030 SHALL, on reset mid-window, discard the partial window, ignore any rd_req in that cycle, and start a full window on the first cycle after reset.
REQ-031 SHALL treat the post-reset previous level as LOW, so an input held high counts one rising edge.

Configuration
REQ-032 SHALL, with LOGIC_PROBE_PULSE_STRETCH_EN defined, hold pulse_led[n] high for STRETCH_CYCLES after any level change on channel n, with a new change restarting the count.
REQ-033 SHALL, without LOGIC_PROBE_PULSE_STRETCH_EN, tie pulse_led and status bit3 to 0, ignore STRETCH_CYCLES, and instantiate no stretch timers.

Verification
REQ-034 SHALL cover: WINDOW_CYCLES=100, 7 full hi/lo pulses on ch0 -> after window_done, read addr 0 = 7, addr 1 = 7, addr 4*CHANNELS = 1.
REQ-035 SHALL cover: hi=1, lo=0 on ch1 for 1 cycle, then MID -> status read (addr 6) bit2=1, second read bit2=0.
REQ-036 SHALL cover: COUNTER_BITS=3, 20 rising edges in one window -> snapshot reads 7.
REQ-037 SHALL cover: rising edge landing on the terminal cycle -> snapshot excludes it, next window reports it (count 1).
REQ-038 SHALL cover: back-to-back rd_req to addrs 0, 2, 200 -> three consecutive rd_ack, data snapshot/status/0.
REQ-039 SHALL cover: with the macro, STRETCH_CYCLES=10, one transition -> pulse_led high exactly 10 cycles; reset asserted mid-stretch -> pulse_led 0 next cycle.
